// File: rtl/seletor_ativo_par_pkg.sv
// Shared definitions for the active-node selector: width helper, FSM encodings
// and criterion sentinels (sliced to CRITERIO_WIDTH by the users).
package seletor_ativo_par_pkg;

    function automatic int clog2(input int valor);
        int r;
        int v;
        r = 0;
        v = valor - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    // Wide enough for any practical criterion width; users keep the low bits.
    localparam logic [31:0] CRIT_MAX_SENTINEL = '1;
    localparam logic [31:0] CRIT_MIN_SENTINEL = '0;

endpackage

// File: rtl/seletor_ativo_par_comparador_lanes.sv
// Combinational reduction of the running best against LANES candidates,
// keeping the lowest index on ties.
module comparador_lanes #(
    parameter int LANES          = 4,
    parameter int CRITERIO_WIDTH = 5,
    parameter int IDX_WIDTH      = 4
) (
    input  logic                             modo_max_in,
    input  logic [CRITERIO_WIDTH-1:0]        best_crit_in,
    input  logic                             best_valido_in,
    input  logic [IDX_WIDTH-1:0]             best_idx_in,
    input  logic [LANES*CRITERIO_WIDTH-1:0]  cand_crit_in,
    input  logic [LANES-1:0]                 cand_ativo_in,
    input  logic [LANES*IDX_WIDTH-1:0]       cand_idx_in,
    output logic [CRITERIO_WIDTH-1:0]        best_crit_out,
    output logic                             best_valido_out,
    output logic [IDX_WIDTH-1:0]             best_idx_out
);

    logic [CRITERIO_WIDTH-1:0] crit_l;
    logic                      melhor_l;

    // NOTE: every signal driven here gets a default before the loop, so no latch is inferred.
    always_comb begin
        best_crit_out   = best_crit_in;
        best_valido_out = best_valido_in;
        best_idx_out    = best_idx_in;
        crit_l          = '0;
        melhor_l        = 1'b0;
        // Lanes are visited in ascending index order, and only a strict
        // improvement displaces the current best, so ties keep the lower index.
        for (int l = 0; l < LANES; l++) begin
            crit_l   = cand_crit_in[l*CRITERIO_WIDTH +: CRITERIO_WIDTH];
            melhor_l = modo_max_in ? (crit_l > best_crit_out) : (crit_l < best_crit_out);
            if (cand_ativo_in[l] && (!best_valido_out || melhor_l)) begin
                best_crit_out   = crit_l;
                best_valido_out = 1'b1;
                best_idx_out    = cand_idx_in[l*IDX_WIDTH +: IDX_WIDTH];
            end
        end
    end

endmodule

// File: rtl/seletor_ativo_par.sv
// Active-node classifier: snapshots NUM_NA criteria/flags on start_in and scans
// them LANES per cycle, reporting the min/max active criterion and its index.
module seletor_ativo_par
    import seletor_ativo_par_pkg::*;
#(
    parameter  int NUM_NA         = 16,
    parameter  int CRITERIO_WIDTH = 5,
    parameter  int LANES          = 4,
    localparam int IDX_WIDTH      = clog2(NUM_NA)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start_in,
    input  logic                               modo_max_in,
    input  logic [NUM_NA-1:0]                  na_ativo_in,
    input  logic [NUM_NA*CRITERIO_WIDTH-1:0]   na_criterio_in,
    output logic                               busy_o,
    output logic                               pronto_o,
    output logic                               valido_o,
    output logic [CRITERIO_WIDTH-1:0]          criterio_out,
    output logic [IDX_WIDTH-1:0]               indice_out
);

    localparam int BEATS      = (NUM_NA + LANES - 1) / LANES;
    localparam int BEAT_WIDTH = (clog2(BEATS) > 1) ? clog2(BEATS) : 1;
    localparam int TOTAL      = BEATS * LANES;
    localparam logic [CRITERIO_WIDTH-1:0] SENT_MAX = CRIT_MAX_SENTINEL[CRITERIO_WIDTH-1:0];
    localparam logic [CRITERIO_WIDTH-1:0] SENT_MIN = CRIT_MIN_SENTINEL[CRITERIO_WIDTH-1:0];

    logic [0:0]                          estado_q, estado_d;
    logic [BEAT_WIDTH-1:0]               beat_q, beat_d;
    logic [NUM_NA-1:0]                   ativo_q, ativo_d;
    logic [NUM_NA*CRITERIO_WIDTH-1:0]    crit_q, crit_d;
    logic                                modo_q, modo_d;
    logic [CRITERIO_WIDTH-1:0]           best_crit_q, best_crit_d;
    logic                                best_valido_q, best_valido_d;
    logic [IDX_WIDTH-1:0]                best_idx_q, best_idx_d;
    logic                                pronto_q, pronto_d;
    logic                                valido_q, valido_d;
    logic [CRITERIO_WIDTH-1:0]           criterio_q, criterio_d;
    logic [IDX_WIDTH-1:0]                indice_q, indice_d;

    logic [TOTAL-1:0]                    ativo_pad;
    logic [TOTAL*CRITERIO_WIDTH-1:0]     crit_pad;
    int                                  base;
    logic [LANES-1:0]                    cand_ativo;
    logic [LANES*CRITERIO_WIDTH-1:0]     cand_crit;
    logic [LANES*IDX_WIDTH-1:0]          cand_idx;
    logic [CRITERIO_WIDTH-1:0]           red_crit;
    logic                                red_valido;
    logic [IDX_WIDTH-1:0]                red_idx;
    logic                                ultimo_beat;

    // Zero padding past NUM_NA makes the phantom lanes of a partial last beat inactive.
    always_comb begin
        ativo_pad                          = '0;
        crit_pad                           = '0;
        ativo_pad[NUM_NA-1:0]              = ativo_q;
        crit_pad[NUM_NA*CRITERIO_WIDTH-1:0] = crit_q;
        base                               = int'(beat_q) * LANES;
        cand_ativo = LANES'(ativo_pad >> base);
        cand_crit  = (LANES*CRITERIO_WIDTH)'(crit_pad >> (base * CRITERIO_WIDTH));
        cand_idx   = '0;
        for (int l = 0; l < LANES; l++) begin
            cand_idx[l*IDX_WIDTH +: IDX_WIDTH] = IDX_WIDTH'(base + l);
        end
    end

    comparador_lanes #(
        .LANES          (LANES),
        .CRITERIO_WIDTH (CRITERIO_WIDTH),
        .IDX_WIDTH      (IDX_WIDTH)
    ) u_comparador (
        .modo_max_in     (modo_q),
        .best_crit_in    (best_crit_q),
        .best_valido_in  (best_valido_q),
        .best_idx_in     (best_idx_q),
        .cand_crit_in    (cand_crit),
        .cand_ativo_in   (cand_ativo),
        .cand_idx_in     (cand_idx),
        .best_crit_out   (red_crit),
        .best_valido_out (red_valido),
        .best_idx_out    (red_idx)
    );

    assign ultimo_beat = (beat_q == BEAT_WIDTH'(BEATS - 1));

    always_comb begin
        estado_d      = estado_q;
        beat_d        = beat_q;
        ativo_d       = ativo_q;
        crit_d        = crit_q;
        modo_d        = modo_q;
        best_crit_d   = best_crit_q;
        best_valido_d = best_valido_q;
        best_idx_d    = best_idx_q;
        pronto_d      = 1'b0;
        valido_d      = valido_q;
        criterio_d    = criterio_q;
        indice_d      = indice_q;

        if (estado_q == ST_SCAN) begin
            best_crit_d   = red_crit;
            best_valido_d = red_valido;
            best_idx_d    = red_idx;
            beat_d        = beat_q + 1'b1;
            if (ultimo_beat) begin
                estado_d   = ST_IDLE;
                pronto_d   = 1'b1;
                valido_d   = red_valido;
                criterio_d = red_crit;
                indice_d   = red_idx;
            end
        end

        // A start overrides the scan state (abort/restart) but never the result write above.
        if (start_in) begin
            estado_d      = ST_SCAN;
            beat_d        = '0;
            ativo_d       = na_ativo_in;
            crit_d        = na_criterio_in;
            modo_d        = modo_max_in;
            best_crit_d   = modo_max_in ? SENT_MIN : SENT_MAX;
            best_valido_d = 1'b0;
            best_idx_d    = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments only; all next values come from the comb block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q      <= ST_IDLE;
            beat_q        <= '0;
            ativo_q       <= '0;
            crit_q        <= '0;
            modo_q        <= 1'b0;
            best_crit_q   <= SENT_MAX;
            best_valido_q <= 1'b0;
            best_idx_q    <= '0;
            pronto_q      <= 1'b0;
            valido_q      <= 1'b0;
            criterio_q    <= SENT_MAX;
            indice_q      <= '0;
        end else begin
            estado_q      <= estado_d;
            beat_q        <= beat_d;
            ativo_q       <= ativo_d;
            crit_q        <= crit_d;
            modo_q        <= modo_d;
            best_crit_q   <= best_crit_d;
            best_valido_q <= best_valido_d;
            best_idx_q    <= best_idx_d;
            pronto_q      <= pronto_d;
            valido_q      <= valido_d;
            criterio_q    <= criterio_d;
            indice_q      <= indice_d;
        end
    end

    assign busy_o       = (estado_q == ST_SCAN);
    assign pronto_o     = pronto_q;
    assign valido_o     = valido_q;
    assign criterio_out = criterio_q;
    assign indice_out   = indice_q;

endmodule

// File: doc/seletor_ativo_par.md
Name: seletor_ativo_par

Overview:
- Next-generation active-node classifier for the path-search datapath.
- Takes a snapshot of NUM_NA node criteria and active flags, then scans them LANES per cycle.
- Returns the best criterion (minimum, or maximum if selected) among active nodes, together with its node index and a valid flag.
- Uses a start/busy/pronto handshake; the criterion-update controller consumes the result.

Parameters:
NUM_NA, 16, number of nodes; must be >= 2
CRITERIO_WIDTH, 5, criterion width in bits
LANES, 4, nodes compared per scan cycle; 1 <= LANES <= NUM_NA; need not divide NUM_NA
(derived) IDX_WIDTH = clog2(NUM_NA); BEATS = ceil(NUM_NA/LANES); BEAT_WIDTH = max(1, clog2(BEATS))

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_in  in  1  one-cycle request; snapshot the inputs and begin a scan
modo_max_in  in  1  sampled with start_in; 0 = select minimum, 1 = select maximum
na_ativo_in  in  NUM_NA  per-node active flag, bit i belongs to node i
na_criterio_in  in  NUM_NA*CRITERIO_WIDTH  packed criteria; node i occupies bits [CW*i+CW-1 : CW*i]
busy_o  out  1  high while a scan is in progress
pronto_o  out  1  one-cycle pulse; result outputs are valid
valido_o  out  1  at least one node was active in the completed scan
criterio_out  out  CRITERIO_WIDTH  winning criterion
indice_out  out  IDX_WIDTH  index of the winning node

Behaviour:
- Reset (asynchronous): state IDLE; busy_o=0; pronto_o=0; valido_o=0; criterio_out all ones; indice_out=0; snapshot registers cleared.
- FSM states: IDLE, SCAN.
  - IDLE -> SCAN on start_in.
  - SCAN -> IDLE after the beat BEATS-1 edge.
- Start edge (start_in=1 at rising edge T0):
  - Register na_ativo_in, na_criterio_in and modo_max_in into snapshot registers.
  - beat <= 0.
  - Running best <= sentinel: all ones in min mode, all zeros in max mode; running valid <= 0; running index <= 0.
  - busy_o <= 1.
- Inputs may change freely after T0; only the snapshot is used.
- Scan beat k, edge T(k+1):
  - Candidate set = nodes k*LANES .. k*LANES+LANES-1.
  - Indices >= NUM_NA in the last partial beat are treated as inactive.
  - One combinational reduction over the running best plus LANES candidates, then the running best is updated.
- Comparison rule:
  - A candidate replaces the current best only if it is active AND (running valid == 0 OR strictly better).
  - Strictly better means < in min mode, > in max mode.
  - Ties therefore keep the lowest index.
  - Comparison is unsigned and full CRITERIO_WIDTH.
- Completion, edge T(BEATS):
  - Final running best goes to criterio_out, indice_out and valido_o.
  - pronto_o <= 1 for exactly one cycle; busy_o <= 0.
  - Latency: start edge to pronto_o high = BEATS cycles.
- No active node: valido_o=0, criterio_out = sentinel for the mode used, indice_out=0.
- Outputs hold their value between pronto pulses; they change only on a completion edge or at reset.
- start_in while busy_o=1: abort the current scan and restart with a fresh snapshot at that edge. No pronto_o is issued for the aborted scan; busy_o stays 1.
- start_in on the completion edge: completion takes priority.
  - Results are written and pronto_o pulses.
  - The new snapshot is taken at the same edge, beat=0, and busy_o stays 1.
- Reset mid-scan: immediate return to reset values; no pronto_o.
- LANES >= NUM_NA: BEATS=1, so the block becomes a single-cycle parallel selector with pronto 1 cycle after start.

Decomposition:
- Shared package/header holds:
  - clog2 function
  - FSM state encodings (IDLE, SCAN)
  - sentinel constants (CRIT_MAX_SENTINEL / CRIT_MIN_SENTINEL) derived from CRITERIO_WIDTH
- One sub-module, comparador_lanes: purely combinational.
  - Inputs: running best, valid and index plus LANES (criterion, active, index) tuples, and the mode.
  - Outputs: new best, valid and index.
  - Implemented as a linear or tree reduction that preserves lowest-index tie-breaking.
- The top level keeps the FSM, beat counter, snapshot registers and output registers.

Test Plan:
- Defaults (16/5/4), min mode, all active, criteria[i]=20-i except criteria[9]=2 -> pronto 4 cycles after start; criterio_out=2, indice_out=9, valido_o=1.
- Min mode, active only {3,12}, criteria[3]=7, criteria[12]=7 (tie), other nodes criterion 0 but inactive -> criterio_out=7, indice_out=3.
- Max mode, all active, criteria[i]=i, criteria[15]=31 -> criterio_out=31, indice_out=15; then na_ativo_in=0 -> valido_o=0, criterio_out=0, indice_out=0.
- NUM_NA=10, LANES=4 (BEATS=3), only node 9 active with criterion 5 -> pronto 3 cycles after start; criterio_out=5, indice_out=9; phantom lanes 10-11 ignored.
- Start at T0, second start at T2 with different data -> exactly one pronto pulse at T2+4, carrying the second data set; inputs changed after T2 have no effect.
- Assert rst_n=0 at beat 2 -> busy_o=0, pronto_o never pulses, criterio_out all ones; a later start scans normally.
